seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial pattern detector. It is the successor to the fixed 1010 overlapping Mealy detector and sits on the same single-bit serial input path. The block adds a configurable pattern width, a pattern loadable at run time, an input qualifier, selectable overlap or non-overlap matching, a registered output copy and a saturating match counter.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16
- RESET_PAT, 4'b1010 (PAT_W bits), pattern held after reset
- CNT_W, 8, width of the match counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- in  input  1  serial data bit
- in_valid  input  1  qualifies `in`; bit accepted on a clk edge only when 1
- pat_load  input  1  loads `pat_in` as the new pattern
- pat_in  input  PAT_W  new pattern; MSB is compared against the oldest bit
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- out  output  1  Mealy match flag, combinational in the current cycle
- out_reg  output  1  `out` registered, one clk later
- match_cnt  output  CNT_W  saturating count of matches

## Operation
- **State:**
  - `pat_r[PAT_W-1:0]`: pattern register.
  - `hist[PAT_W-1:0]`: most recent accepted bits, LSB newest.
  - `fill`: count of valid history bits, range 0..PAT_W-1.
- **Candidate and match:**
  - `cand = {hist[PAT_W-2:0], in}`.
  - `match = in_valid & ~pat_load & (fill == PAT_W-1) & (cand == pat_r)`.
  - `out = match`.
- **Accepted bit** (`in_valid=1`, `pat_load=0`) at a clk edge:
  - If `match` and `overlap=0`: `fill <= 0`. History is discarded, so no bit of the matched window is reused.
  - Otherwise: `hist <= cand`; `fill <= min(fill+1, PAT_W-1)`.
  - Overlap mode therefore reuses the trailing PAT_W-1 bits of a match.
- **Idle:** with `in_valid=0`, `hist` and `fill` hold and `out=0`. Gaps in `in_valid` do not break a partial match.
- **Pattern load:** `pat_load=1` at a clk edge does the following.
  - `pat_r <= pat_in`, `fill <= 0`, `match_cnt <= 0`.
  - The `in` bit in that cycle is ignored, even if `in_valid=1`.
  - `out` is forced to 0 during that cycle.
- **Mode change:** `overlap` is evaluated per accepted bit. A change takes effect at the next match and needs no flush.
- **Counter:** `match_cnt` increments by 1 on each edge where `match=1`. It saturates at 2^CNT_W-1 and does not wrap.
- **Reset** (`rst=0`, asynchronous, any time including mid-pattern):
  - `pat_r = RESET_PAT`, `hist = 0`, `fill = 0`.
  - `out_reg = 0`, `match_cnt = 0`.
  - `out = 0` while reset is asserted.
  - After release, the first match needs PAT_W fresh accepted bits.

## Timing
- `out`:
  - Zero-latency Mealy output, valid in the same cycle as the last pattern bit on `in`.
  - Sample it at the rising edge that accepts that bit.
  - Combinational from `in`, `in_valid`, `pat_load` and registered state only.
- `out_reg` equals `out` from the previous edge; it is a 1-cycle pulse per match.
- `match_cnt` shows the updated value one clk after the matching edge.
- First possible match is on the PAT_W-th accepted bit after reset or pattern load.
- Reset assertion clears state immediately, with no clk needed. Release is synchronised externally and is not handled in the block.
- `pat_load` and `in_valid` asserted together: the load wins and the bit is dropped.

## Test plan
- **Reset pattern, overlap=1:** stream 1,0,1,0,0,1,0,1,0 with `in_valid=1`, 10-unit clk period.
  - `out=1` on accepted bits 4 and 9 only.
  - `out_reg` high the cycle after each; final `match_cnt=2`.
- **Overlap vs non-overlap:** stream 1,0,1,0,1,0.
  - `overlap=1`: `out=1` on bits 4 and 6.
  - `overlap=0`: `out=1` on bit 4 only; `match_cnt` ends at 2 and 1 respectively.
- **Run-time load:** pulse `pat_load` with `pat_in=4'b1101` while driving `in_valid=1`, `in=1` in the same cycle.
  - That bit is ignored and `match_cnt` reads 0.
  - Then stream 1,1,0,1,1,0,1 with `overlap=1`: `out=1` on bits 4 and 7.
- **Gaps:** stream 1,0 then `in_valid=0` for 3 cycles, then 1,0.
  - `out` is 0 during the gap and 1 on the final bit.
- **Reset mid-pattern:** after 1,0,1, assert `rst=0` between edges.
  - `out_reg`, `match_cnt` and `fill` clear immediately.
  - After release, 0 then 1,0,1,0 gives the first match only on the final 0.
- **Saturation:** with CNT_W=2 and `overlap=1`, send 1010 followed by 10 repeated four more times (5 matches).
  - `match_cnt` sequence is 1,2,3,3,3.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with a run-time
// loadable pattern, an input qualifier, overlap/non-overlap matching, a
// registered copy of the match flag and a saturating match counter.
module seq_detect_param #(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1010),
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    output logic             out,
    output logic             out_reg,
    output logic [CNT_W-1:0] match_cnt
);

    // fill counts valid history bits and tops out at PAT_W-1
    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_reg;
    // only the newest PAT_W-1 bits are ever needed to form a candidate
    logic [PAT_W-2:0]  hist_reg;
    logic [FILL_W-1:0] fill_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [PAT_W-1:0]  cand;
    logic              accept;
    logic              match;

    // a load cycle drops the incoming bit, so it can never match
    assign cand   = {hist_reg, in};
    assign accept = in_valid & ~pat_load;
    assign match  = accept & (fill_reg == FILL_MAX) & (cand == pat_reg);

    assign out       = match;
    assign match_cnt = cnt_reg;

    // pattern register: reset value or run-time load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg <= RESET_PAT;
        end else if (pat_load) begin
            pat_reg <= pat_in;
        end
    end

    // history shift and fill tracking; non-overlap discards the matched window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (pat_load) begin
            fill_reg <= '0;
        end else if (in_valid) begin
            if (match && !overlap) begin
                fill_reg <= '0;
            end else begin
                hist_reg <= cand[PAT_W-2:0];
                fill_reg <= (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + 1'b1;
            end
        end
    end

    // one-cycle delayed copy of the Mealy match flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_reg <= 1'b0;
        end else begin
            out_reg <= match;
        end
    end

    // saturating match counter, cleared by a pattern load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (pat_load) begin
            cnt_reg <= '0;
        end else if (match && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule
